pattern_serializer: RTL
=======================

# pattern_serializer

Upstream feeder for the Moore sequence detector. It accepts parallel test words through a valid/ready handshake and buffers them in a small FIFO. It then shifts them out one bit per clock on `r`, with no gaps between queued words. `r` connects directly to the detector's `r` input. `r_valid` and `word_done` let the bench align the detector's `out` against the bit stream.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word; must be at least 2.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `MSB_FIRST`, default 1: 1 shifts from bit `WIDTH-1` down to bit 0; 0 shifts from bit 0 up.
- `IDLE_BIT`, default 0: level driven on `r` when no word is being shifted.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state changes on its rising edge.
- `state_reset`  in  1: reset, synchronous and active-high.
- `in_data`  in  `WIDTH`: word to enqueue.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: FIFO can accept a word this cycle.
- `r`  out  1: serial bit to the detector; registered.
- `r_valid`  out  1: `r` carries a data bit this cycle; registered.
- `word_done`  out  1: high in the cycle `r` carries the last bit of a word; registered.
- `fifo_count`  out  `$clog2(DEPTH)+1`: number of queued words, not counting the word currently shifting.

## Operation
- Push occurs when `in_valid && in_ready` at a rising edge.
- `in_ready` is `(fifo_count < DEPTH) && !state_reset`.
  - `in_ready` does not depend on a same-cycle pop, so a full FIFO never accepts a word.
- Serializer FSM has two states, IDLE and SHIFT.
- IDLE:
  - `r` = `IDLE_BIT`, `r_valid` = 0, `word_done` = 0.
  - If FIFO is non-empty: pop the head word, load the shift register, set `bit_cnt` = `WIDTH-1`, drive the first bit on `r`, assert `r_valid`, go to SHIFT.
- SHIFT:
  - Each edge presents the next bit and decrements `bit_cnt`.
  - When `bit_cnt` = 0, the current bit is the last one and `word_done` = 1.
  - On that last-bit cycle, if the FIFO is non-empty: pop and load the next word, so its first bit follows on the next cycle (gapless).
  - Otherwise return to IDLE, so `r` goes back to `IDLE_BIT` on the next cycle.
- No fall-through: a word pushed into an empty FIFO cannot be popped in the same edge.
- Push and pop in the same edge with a non-empty FIFO: `fifo_count` is unchanged.
- FIFO read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Full when `fifo_count` = `DEPTH`; empty when 0.
- `bit_cnt` is `$clog2(WIDTH)` bits and never underflows: reload or IDLE always happens at 0.

## Timing
- Reset values, applied on the first edge with `state_reset` high:
  - FIFO emptied, `fifo_count` = 0, pointers = 0.
  - FSM = IDLE, `r` = `IDLE_BIT`, `r_valid` = 0, `word_done` = 0.
- While reset is high, `in_ready` = 0 and pushes are ignored.
- Reset mid-word discards the shifting word and every queued word; there is no partial completion.
- Latency: a word accepted at edge N into an idle, empty block drives its first bit after edge N+1. The last bit follows after edge N+`WIDTH`.
- Each bit is held for exactly one cycle.
- Sustained throughput is one word per `WIDTH` cycles.
- `word_done` is a one-cycle pulse per word, coincident with the last bit.

## Structure
- Package `serializer_pkg` holds:
  - FSM state typedef (IDLE, SHIFT, as a 1-bit enum);
  - the `IDLE_BIT` default;
  - a `CNT_W(depth)` helper constant function.
- Sub-module `word_fifo` (`WIDTH`, `DEPTH`) provides:
  - ports `push`, `pop`, `wdata`, `rdata`, `count`, `full`, `empty`;
  - registered storage, synchronous reset, with `rdata` = head entry.
- Top level contains the handshake logic, the FSM, the shift register and `bit_cnt`.

## Test plan
- Single-word timing: `WIDTH`=8, MSB_FIRST, push 8'b0010_1111 at edge 1 -> `r_valid` high after edges 2 through 9, `r` = 0,0,1,0,1,1,1,1. `word_done` only on the last of those cycles; `r` = `IDLE_BIT` afterwards.
- Gapless back-to-back: push 8'hA5 then 8'h3C on consecutive cycles -> 16 contiguous `r_valid` cycles, `r` = 10100101 00111100, two `word_done` pulses 8 cycles apart.
- FIFO full/backpressure: hold `in_valid` high with `DEPTH`=4 -> 5 words accepted (1 shifting plus 4 queued), then `in_ready` = 0 and `fifo_count` = 4. `in_ready` returns high the cycle after the next pop. No word is lost or duplicated.
- Reset mid-word: assert `state_reset` for 1 cycle at bit 3 of a word with 2 queued -> next cycle `r` = `IDLE_BIT`, `r_valid` = 0, `fifo_count` = 0. A later push restarts with correct latency.
- Detector pattern, LSB-first: `WIDTH`=9, MSB_FIRST=0, push 9'b011110100 -> `r` = 0,0,1,0,1,1,1,1,0. The detector's `out` matches the golden model for that stream.
- Simultaneous push and pop: push while the FIFO is non-empty on the last-bit cycle -> `fifo_count` unchanged, and pointer wrap past `DEPTH` keeps word order intact.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the pattern serializer and its word FIFO.
package serializer_pkg;

   // Serializer FSM: IDLE drives the idle level, SHIFT drives data bits.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Level driven on r when no word is being shifted.
   localparam logic IDLE_BIT_DEFAULT = 1'b0;

   // Occupancy counter width: must be able to hold the value depth itself.
   function automatic int CNT_W(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO: array storage, wrapping pointers, head word always
// visible on rdata. Push when full and pop when empty are ignored.
module word_fifo
   import serializer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [CNT_W(DEPTH)-1:0]  count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = CNT_W(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full && !srst;
   assign do_pop  = pop && !empty;

   // Storage write; no reset so the array can map onto plain memory.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

endmodule

// File: rtl/pattern_serializer.sv
// Accepts parallel words over valid/ready, queues them, and shifts them out
// one bit per clock on r with no gap between queued words.
module pattern_serializer
   import serializer_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter int   DEPTH     = 4,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     state_reset,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     r,
   output logic                     r_valid,
   output logic                     word_done,
   output logic [CNT_W(DEPTH)-1:0]  fifo_count
);

   localparam int BC_W = $clog2(WIDTH);
   localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WIDTH - 1);
   localparam logic [BC_W-1:0] ONE_CNT  = BC_W'(1);

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic             r_q, r_d;
   logic             r_valid_q, r_valid_d;
   logic             word_done_q, word_done_d;

   logic             push;
   logic             pop;
   logic             load;
   logic             advance;
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;

   // Readiness ignores a same-cycle pop, so a full FIFO never accepts.
   assign in_ready = !fifo_full && !state_reset;
   assign push     = in_valid && in_ready;

   word_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .srst  (state_reset),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state logic: load a fresh word, step through the current one, or idle.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      r_d         = IDLE_BIT;
      r_valid_d   = 1'b0;
      word_done_d = 1'b0;
      load        = 1'b0;
      advance     = 1'b0;
      src         = shift_q;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               load = 1'b1;
            end
         end
         SHIFT: begin
            if (bit_cnt_q != '0) begin
               advance     = 1'b1;
               bit_cnt_d   = bit_cnt_q - 1'b1;
               word_done_d = (bit_cnt_q == ONE_CNT);
            end else if (!fifo_empty) begin
               load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A loaded word is emitted from the FIFO head; otherwise from the shifter.
      if (load) begin
         src       = fifo_rdata;
         state_d   = SHIFT;
         bit_cnt_d = LAST_IDX;
      end

      if (load || advance) begin
         r_valid_d = 1'b1;
         if (MSB_FIRST != 0) begin
            r_d     = src[WIDTH-1];
            shift_d = src << 1;
         end else begin
            r_d     = src[0];
            shift_d = src >> 1;
         end
      end
   end

   assign pop = load;

   // State and registered serial outputs.
   always_ff @(posedge clk) begin
      if (state_reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         r_q         <= IDLE_BIT;
         r_valid_q   <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         r_q         <= r_d;
         r_valid_q   <= r_valid_d;
         word_done_q <= word_done_d;
      end
   end

   assign r         = r_q;
   assign r_valid   = r_valid_q;
   assign word_done = word_done_q;

endmodule
